branch_resolve: RTL and testbench
=================================

# branch_resolve

Branch-resolution unit sitting downstream of the ALU flag outputs: it captures the condition flags produced by CMP/TEST, tracks compares still in flight between decode and execute, and resolves conditional branches against the captured flags. It accepts one branch at a time over a valid/ready handshake, stalls a branch until all older compares have written flags, and returns taken/not-taken plus the redirect PC to fetch.

## Interface
- DATA_WIDTH, 32, datapath width (only for flag source consistency; no data bus enters the block)
- ADDR_WIDTH, 16, PC width in words
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high; all state cleared while high
- cmp_issue  in  1  decode issued a CMP or TEST this cycle
- cmp_stall  out  1  outstanding-compare counter full; decode must not assert cmp_issue
- flag_wr_en  in  1  ALU executed CMP/TEST this cycle; zero/less valid
- zero  in  1  ALU zero flag
- less  in  1  ALU unsigned less-than flag
- br_valid  in  1  branch request valid
- br_ready  out  1  block can accept a branch
- br_cond  in  3  condition code
- br_pc  in  ADDR_WIDTH  PC of the branch
- br_target  in  ADDR_WIDTH  taken target
- flush  in  1  abort any accepted, unresolved branch
- resolve_valid  out  1  one-cycle pulse: result valid
- taken  out  1  branch taken
- redirect_pc  out  ADDR_WIDTH  next PC (target or fall-through)
- flags  out  3  registered {greater, less, zero} for debug

## Operation
- Flag register: Z, L updated at every clk edge where flag_wr_en=1; G is derived as !Z & !L (the ALU greater input is not used).
- Outstanding counter (2 bits, 0..3): +1 on cmp_issue, -1 on flag_wr_en, unchanged when both. flag_wr_en at count 0 writes flags but does not underflow. cmp_stall = (count==3); cmp_issue at count 3 is a protocol violation, ignored, flagged by assertion.
- Conditions: 0 ALWAYS, 1 EQ (Z), 2 NE (!Z), 3 LT (L), 4 LE (L|Z), 5 GT (G), 6 GE (!L), 7 NEVER.
- FSM states IDLE, WAIT_FLAGS, RESOLVE. br_ready = (state==IDLE).
- IDLE: on br_valid, latch cond/pc/target. Go RESOLVE if cond is ALWAYS/NEVER or count==0 (after this cycle's update), else WAIT_FLAGS.
- WAIT_FLAGS: stay until next-count==0, then RESOLVE.
- RESOLVE: evaluate latched cond against flag register; pulse resolve_valid; taken per table; redirect_pc = taken ? target : pc+1 (mod 2^ADDR_WIDTH); return to IDLE.
- flush in WAIT_FLAGS or RESOLVE: go IDLE, no resolve_valid that cycle. Flush in IDLE with br_valid: request not accepted. Counter and flag register unaffected by flush.

## Timing
- Reset: state IDLE, count 0, Z=L=0 (flags=3'b100), resolve_valid=0, taken=0, redirect_pc=0, cmp_stall=0; br_ready=1 after reset.
- No pending compare: accept at edge N, resolve_valid high during cycle N+1, br_ready high again cycle N+2. Throughput one branch per 2 cycles.
- Pending compare: resolve_valid one cycle after the edge where the last flag_wr_en brings count to 0; RESOLVE sees the flags written at that edge.
- Same-cycle cmp_issue and branch acceptance: the new compare counts as older; branch waits for it.
- resolve_valid, taken, redirect_pc registered; hold 0/last value outside the pulse (taken, redirect_pc hold last value).
- reset asserted mid-WAIT_FLAGS: immediate return to IDLE, no pulse.

## Structure
- Shared defines package: BR_COND_* codes, FSM state encodings, flag bit positions.
- Sub-module flag_file: flag register plus outstanding-compare counter and cmp_stall; top holds FSM and PC mux.

## Test plan
- Reset, then br_valid cond=ALWAYS pc=0x0010 target=0x0040 -> resolve_valid next cycle, taken=1, redirect_pc=0x0040.
- flag_wr_en zero=1 less=0, then EQ pc=0x0020 -> taken=1; NE -> taken=0, redirect_pc=0x0021; GT -> taken=0.
- cmp_issue x2, branch LT accepted, flag_wr_en (less=0) then flag_wr_en (less=1) 3 cycles later -> resolve_valid exactly one cycle after second write, taken=1.
- Issue 3 compares -> cmp_stall=1; one flag_wr_en with cmp_issue same cycle -> count stays 3, stall stays 1.
- Branch in WAIT_FLAGS, flush -> no resolve_valid, br_ready=1 next cycle; pc=0xFFFF NEVER -> redirect_pc=0x0000.
- Reset asserted during WAIT_FLAGS -> all outputs reset values asynchronously, count 0.

Source files
------------

// File: rtl/branch_resolve_pkg.sv
// Shared definitions for the branch-resolution slice: condition codes, FSM
// encodings, flag bit positions and the condition evaluator.
package branch_resolve_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int ADDR_WIDTH = 16;

    localparam int FLAG_Z = 0;
    localparam int FLAG_L = 1;
    localparam int FLAG_G = 2;

    typedef enum logic [2:0] {
        BR_COND_ALWAYS = 3'd0,
        BR_COND_EQ     = 3'd1,
        BR_COND_NE     = 3'd2,
        BR_COND_LT     = 3'd3,
        BR_COND_LE     = 3'd4,
        BR_COND_GT     = 3'd5,
        BR_COND_GE     = 3'd6,
        BR_COND_NEVER  = 3'd7
    } br_cond_e;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_WAIT_FLAGS = 2'd1,
        ST_RESOLVE    = 2'd2
    } br_state_e;

    // Greater is not taken from the ALU; it is implied by neither zero nor less.
    function automatic logic [2:0] make_flags(input logic z, input logic l);
        logic [2:0] f;
        f         = 3'b000;
        f[FLAG_Z] = z;
        f[FLAG_L] = l;
        f[FLAG_G] = ~z & ~l;
        return f;
    endfunction

    function automatic logic cond_taken(input logic [2:0] cond, input logic [2:0] fl);
        logic t;
        case (cond)
            BR_COND_ALWAYS: t = 1'b1;
            BR_COND_EQ:     t = fl[FLAG_Z];
            BR_COND_NE:     t = ~fl[FLAG_Z];
            BR_COND_LT:     t = fl[FLAG_L];
            BR_COND_LE:     t = fl[FLAG_L] | fl[FLAG_Z];
            BR_COND_GT:     t = fl[FLAG_G];
            BR_COND_GE:     t = ~fl[FLAG_L];
            BR_COND_NEVER:  t = 1'b0;
            default:        t = 1'b0;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/branch_resolve_if.sv
// Pipeline-side bundle of the branch-resolution unit: compare tracking, ALU
// flags, branch request handshake and the resolution result.
interface branch_resolve_if #(
    parameter int ADDR_WIDTH = 16
);
    logic                  cmp_issue;
    logic                  cmp_stall;
    logic                  flag_wr_en;
    logic                  zero;
    logic                  less;
    logic                  br_valid;
    logic                  br_ready;
    logic [2:0]            br_cond;
    logic [ADDR_WIDTH-1:0] br_pc;
    logic [ADDR_WIDTH-1:0] br_target;
    logic                  flush;
    logic                  resolve_valid;
    logic                  taken;
    logic [ADDR_WIDTH-1:0] redirect_pc;
    logic [2:0]            flags;

    modport master (
        output cmp_issue, flag_wr_en, zero, less,
        output br_valid, br_cond, br_pc, br_target, flush,
        input  cmp_stall, br_ready, resolve_valid, taken, redirect_pc, flags
    );

    modport slave (
        input  cmp_issue, flag_wr_en, zero, less,
        input  br_valid, br_cond, br_pc, br_target, flush,
        output cmp_stall, br_ready, resolve_valid, taken, redirect_pc, flags
    );
endinterface

// File: rtl/branch_resolve_checker.sv
// Protocol and output-shape properties for the branch-resolution unit.
module branch_resolve_checker (
    input logic       clk,
    input logic       reset,
    input logic       cmp_issue,
    input logic       flag_wr_en,
    input logic [1:0] count,
    input logic       resolve_valid
);

    // Issuing a compare into a full counter would be lost; a same-cycle write keeps it balanced.
    a_no_issue_when_full: assert property (@(posedge clk) disable iff (reset)
        !(cmp_issue && !flag_wr_en && (count == 2'd3)));

    a_resolve_single_pulse: assert property (@(posedge clk) disable iff (reset)
        resolve_valid |=> !resolve_valid);

endmodule

// File: rtl/branch_resolve_flag_file.sv
// Condition-flag register and outstanding-compare counter. Exposes next-cycle
// values so the FSM can resolve against flags written on the same edge.
module branch_resolve_flag_file
    import branch_resolve_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       cmp_issue,
    input  logic       flag_wr_en,
    input  logic       zero,
    input  logic       less,
    output logic [2:0] flags,
    output logic [2:0] flags_next,
    output logic [1:0] count,
    output logic [1:0] count_next,
    output logic       cmp_stall
);

    logic [2:0] flags_r;
    logic [2:0] flags_next_s;
    logic [1:0] count_r;
    logic [1:0] count_next_s;
    logic       stall_r;

    // Next flag value and saturating compare count (issue and write together cancel).
    always_comb begin
        flags_next_s = flags_r;
        count_next_s = count_r;
        if (flag_wr_en) begin
            flags_next_s = make_flags(zero, less);
        end else begin
            flags_next_s = flags_r;
        end
        case ({cmp_issue, flag_wr_en})
            2'b10:   count_next_s = (count_r == 2'd3) ? count_r : count_r + 2'd1;
            2'b01:   count_next_s = (count_r == 2'd0) ? count_r : count_r - 2'd1;
            default: count_next_s = count_r;
        endcase
    end

    // Flag, counter and stall registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flags_r <= 3'b100;
            count_r <= 2'd0;
            stall_r <= 1'b0;
        end else begin
            flags_r <= flags_next_s;
            count_r <= count_next_s;
            stall_r <= (count_next_s == 2'd3);
        end
    end

    assign flags      = flags_r;
    assign flags_next = flags_next_s;
    assign count      = count_r;
    assign count_next = count_next_s;
    assign cmp_stall  = stall_r;

endmodule

// File: rtl/branch_resolve.sv
// Branch-resolution top: accepts one branch at a time, waits for older
// compares to write flags, then reports taken and the redirect PC.
module branch_resolve
    import branch_resolve_pkg::*;
#(
    parameter int ADDR_WIDTH = 16
) (
    input logic             clk,
    input logic             reset,
    branch_resolve_if.slave bus
);

    logic [2:0]            flags_s;
    logic [2:0]            flags_next_s;
    logic [1:0]            count_s;
    logic [1:0]            count_next_s;
    logic                  cmp_stall_s;

    br_state_e             state_r;
    br_state_e             state_next_s;
    logic                  latch_s;
    logic                  fire_s;
    logic [2:0]            cond_r;
    logic [ADDR_WIDTH-1:0] pc_r;
    logic [ADDR_WIDTH-1:0] target_r;
    logic [2:0]            cond_sel_s;
    logic [ADDR_WIDTH-1:0] pc_sel_s;
    logic [ADDR_WIDTH-1:0] target_sel_s;
    logic                  taken_s;
    logic [ADDR_WIDTH-1:0] redirect_s;
    logic                  resolve_valid_r;
    logic                  taken_r;
    logic [ADDR_WIDTH-1:0] redirect_pc_r;

    branch_resolve_flag_file u_flag_file (
        .clk        (clk),
        .reset      (reset),
        .cmp_issue  (bus.cmp_issue),
        .flag_wr_en (bus.flag_wr_en),
        .zero       (bus.zero),
        .less       (bus.less),
        .flags      (flags_s),
        .flags_next (flags_next_s),
        .count      (count_s),
        .count_next (count_next_s),
        .cmp_stall  (cmp_stall_s)
    );

    branch_resolve_checker u_checker (
        .clk           (clk),
        .reset         (reset),
        .cmp_issue     (bus.cmp_issue),
        .flag_wr_en    (bus.flag_wr_en),
        .count         (count_s),
        .resolve_valid (resolve_valid_r)
    );

    // Next state; fire_s marks the edge entering RESOLVE, where the result registers load.
    always_comb begin
        state_next_s = state_r;
        latch_s      = 1'b0;
        fire_s       = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (bus.br_valid && !bus.flush) begin
                    latch_s = 1'b1;
                    if ((bus.br_cond == BR_COND_ALWAYS) || (bus.br_cond == BR_COND_NEVER) ||
                        (count_next_s == 2'd0)) begin
                        state_next_s = ST_RESOLVE;
                        fire_s       = 1'b1;
                    end else begin
                        state_next_s = ST_WAIT_FLAGS;
                    end
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_WAIT_FLAGS: begin
                if (bus.flush) begin
                    state_next_s = ST_IDLE;
                end else if (count_next_s == 2'd0) begin
                    state_next_s = ST_RESOLVE;
                    fire_s       = 1'b1;
                end else begin
                    state_next_s = ST_WAIT_FLAGS;
                end
            end
            ST_RESOLVE: state_next_s = ST_IDLE;
            default:    state_next_s = ST_IDLE;
        endcase
    end

    // Evaluate against the flags as they stand after this edge's write.
    always_comb begin
        cond_sel_s   = latch_s ? bus.br_cond   : cond_r;
        pc_sel_s     = latch_s ? bus.br_pc     : pc_r;
        target_sel_s = latch_s ? bus.br_target : target_r;
        taken_s      = cond_taken(cond_sel_s, flags_next_s);
        redirect_s   = taken_s ? target_sel_s
                               : pc_sel_s + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
    end

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Branch request capture.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cond_r   <= 3'd0;
            pc_r     <= {ADDR_WIDTH{1'b0}};
            target_r <= {ADDR_WIDTH{1'b0}};
        end else if (latch_s) begin
            cond_r   <= bus.br_cond;
            pc_r     <= bus.br_pc;
            target_r <= bus.br_target;
        end
    end

    // Result registers: one-cycle valid pulse; taken and redirect hold between pulses.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            resolve_valid_r <= 1'b0;
            taken_r         <= 1'b0;
            redirect_pc_r   <= {ADDR_WIDTH{1'b0}};
        end else begin
            resolve_valid_r <= fire_s;
            if (fire_s) begin
                taken_r       <= taken_s;
                redirect_pc_r <= redirect_s;
            end
        end
    end

    assign bus.br_ready      = (state_r == ST_IDLE);
    assign bus.cmp_stall     = cmp_stall_s;
    assign bus.resolve_valid = resolve_valid_r;
    assign bus.taken         = taken_r;
    assign bus.redirect_pc   = redirect_pc_r;
    assign bus.flags         = flags_s;

endmodule

// File: tb/tb_branch_resolve.sv
// Directed self-checking bench for branch_resolve: flag capture, compare
// tracking, condition table, flush, PC wrap and asynchronous reset.
module tb_branch_resolve;
    import branch_resolve_pkg::*;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    branch_resolve_if #(.ADDR_WIDTH(16)) bus ();

    branch_resolve #(.ADDR_WIDTH(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        bus.cmp_issue  = 1'b0;
        bus.flag_wr_en = 1'b0;
        bus.zero       = 1'b0;
        bus.less       = 1'b0;
        bus.br_valid   = 1'b0;
        bus.br_cond    = 3'd0;
        bus.br_pc      = 16'h0000;
        bus.br_target  = 16'h0000;
        bus.flush      = 1'b0;
    endtask

    task automatic branch(input logic [2:0] c, input logic [15:0] pc, input logic [15:0] tgt);
        bus.br_valid  = 1'b1;
        bus.br_cond   = c;
        bus.br_pc     = pc;
        bus.br_target = tgt;
    endtask

    task automatic result(input string tag, input logic rv, input logic tk, input logic [15:0] rpc);
        check({tag, "_valid"}, {31'd0, bus.resolve_valid}, {31'd0, rv});
        check({tag, "_taken"}, {31'd0, bus.taken}, {31'd0, tk});
        check({tag, "_pc"}, {16'd0, bus.redirect_pc}, {16'd0, rpc});
    endtask

    initial begin
        checks = 0;
        errors = 0;
        quiet();
        reset = 1'b1;
        step();
        step();
        result("rst", 1'b0, 1'b0, 16'h0000);
        check("rst_flags", {29'd0, bus.flags}, 32'h4);
        check("rst_stall", {31'd0, bus.cmp_stall}, 32'd0);
        check("rst_ready", {31'd0, bus.br_ready}, 32'd1);
        reset = 1'b0;
        step();

        // ALWAYS with no pending compare: pulse right after acceptance
        branch(3'd0, 16'h0010, 16'h0040);
        step();
        result("always", 1'b1, 1'b1, 16'h0040);
        check("always_busy", {31'd0, bus.br_ready}, 32'd0);
        quiet();
        step();
        check("always_end", {31'd0, bus.resolve_valid}, 32'd0);
        check("always_ready", {31'd0, bus.br_ready}, 32'd1);
        check("always_hold", {31'd0, bus.taken}, 32'd1);

        // Flags Z=1 L=0 -> {G,L,Z}=001
        bus.flag_wr_en = 1'b1;
        bus.zero       = 1'b1;
        step();
        quiet();
        check("flags_z", {29'd0, bus.flags}, 32'h1);
        branch(3'd1, 16'h0020, 16'h0080);
        step();
        result("eq", 1'b1, 1'b1, 16'h0080);
        quiet();
        step();
        branch(3'd2, 16'h0020, 16'h0080);
        step();
        result("ne", 1'b1, 1'b0, 16'h0021);
        quiet();
        step();
        branch(3'd5, 16'h0020, 16'h0080);
        step();
        result("gt", 1'b1, 1'b0, 16'h0021);
        quiet();
        step();

        // Branch resolves against flags written on its own acceptance edge
        bus.flag_wr_en = 1'b1;
        bus.less       = 1'b1;
        branch(3'd3, 16'h0024, 16'h0066);
        step();
        result("lt_same", 1'b1, 1'b1, 16'h0066);
        check("flags_l", {29'd0, bus.flags}, 32'h2);
        quiet();
        step();

        // Two compares in flight, LT waits for both writes
        bus.cmp_issue = 1'b1;
        step();
        step();
        quiet();
        check("two_stall", {31'd0, bus.cmp_stall}, 32'd0);
        branch(3'd3, 16'h0030, 16'h0090);
        step();
        quiet();
        check("wait_ready", {31'd0, bus.br_ready}, 32'd0);
        check("wait_rv0", {31'd0, bus.resolve_valid}, 32'd0);
        bus.flag_wr_en = 1'b1;
        step();
        quiet();
        check("wait_rv1", {31'd0, bus.resolve_valid}, 32'd0);
        step();
        check("wait_rv2", {31'd0, bus.resolve_valid}, 32'd0);
        step();
        check("wait_rv3", {31'd0, bus.resolve_valid}, 32'd0);
        bus.flag_wr_en = 1'b1;
        bus.less       = 1'b1;
        step();
        quiet();
        result("lt_wait", 1'b1, 1'b1, 16'h0090);
        step();
        check("lt_wait_end", {31'd0, bus.resolve_valid}, 32'd0);
        check("lt_wait_ready", {31'd0, bus.br_ready}, 32'd1);

        // Fill the counter, then issue+write together keeps it at 3
        bus.cmp_issue = 1'b1;
        step();
        step();
        check("stall_at2", {31'd0, bus.cmp_stall}, 32'd0);
        step();
        check("stall_at3", {31'd0, bus.cmp_stall}, 32'd1);
        bus.flag_wr_en = 1'b1;
        step();
        check("stall_both", {31'd0, bus.cmp_stall}, 32'd1);
        bus.cmp_issue = 1'b0;
        bus.zero      = 1'b1;
        step();
        quiet();
        check("stall_drain", {31'd0, bus.cmp_stall}, 32'd0);
        check("drain_flags", {29'd0, bus.flags}, 32'h1);

        // Count is 2: flush a waiting branch
        branch(3'd1, 16'h0050, 16'h00a0);
        step();
        quiet();
        check("fl_wait", {31'd0, bus.br_ready}, 32'd0);
        bus.flush = 1'b1;
        step();
        quiet();
        check("fl_rv", {31'd0, bus.resolve_valid}, 32'd0);
        check("fl_ready", {31'd0, bus.br_ready}, 32'd1);
        step();
        check("fl_rv_after", {31'd0, bus.resolve_valid}, 32'd0);

        // Flush in IDLE blocks acceptance
        branch(3'd0, 16'h0060, 16'h00b0);
        bus.flush = 1'b1;
        step();
        quiet();
        check("fl_idle_ready", {31'd0, bus.br_ready}, 32'd1);
        check("fl_idle_rv", {31'd0, bus.resolve_valid}, 32'd0);

        // NEVER ignores pending compares and wraps the fall-through PC
        branch(3'd7, 16'hffff, 16'h1234);
        step();
        quiet();
        result("never_wrap", 1'b1, 1'b0, 16'h0000);
        step();
        branch(3'd0, 16'h0070, 16'h0077);
        step();
        quiet();
        result("always_pend", 1'b1, 1'b1, 16'h0077);
        step();

        // Reset while waiting: outputs clear without waiting for a clock
        branch(3'd6, 16'h0080, 16'h00c0);
        step();
        quiet();
        check("rw_wait", {31'd0, bus.br_ready}, 32'd0);
        #2;
        reset = 1'b1;
        #1;
        result("rw_async", 1'b0, 1'b0, 16'h0000);
        check("rw_flags", {29'd0, bus.flags}, 32'h4);
        check("rw_ready", {31'd0, bus.br_ready}, 32'd1);
        step();
        reset = 1'b0;
        step();
        // Count back at 0: EQ resolves immediately, Z=0 so falls through
        branch(3'd1, 16'h0100, 16'h0200);
        step();
        quiet();
        result("post_rst", 1'b1, 1'b0, 16'h0101);
        check("post_rst_stall", {31'd0, bus.cmp_stall}, 32'd0);
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
